// File: rtl/uart_fifo_bridge_if.sv
// CPU-side register bus of the uart FIFO bridge: one request/acknowledge
// transfer per access, byte data carried in the low half of the 16-bit word.
interface uart_fifo_bridge_if;
    logic        cpu_cs;
    logic [7:0]  cpu_addr;
    logic [1:0]  cpu_ds;
    logic        cpu_rw;
    logic [15:0] cpu_data_write;
    logic [15:0] cpu_data_read;
    logic        cpu_ack;

    modport master (
        output cpu_cs, cpu_addr, cpu_ds, cpu_rw, cpu_data_write,
        input  cpu_data_read, cpu_ack
    );

    modport slave (
        input  cpu_cs, cpu_addr, cpu_ds, cpu_rw, cpu_data_write,
        output cpu_data_read, cpu_ack
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffered bridge between the CPU register bus and the byte-wide uart core:
// TX/RX byte FIFOs on the CPU side, a single-master transaction FSM on the uart side.
module uart_fifo_bridge #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] BASE_ADDR  = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_fifo_bridge_if.slave  cpu,
    output logic               irq,
    output logic [7:0]         u_addr,
    output logic [1:0]         u_ds,
    output logic               u_rw,
    output logic [15:0]        u_data_write,
    input  logic [15:0]        u_data_read,
    input  logic               u_ack,
    input  logic               u_tx_active,
    input  logic               u_rx_avail,
    output logic               u_rx_avail_clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CLR, ST_WR} state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [7:0]            r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
    logic [DEPTH_LOG2:0]   r_tx_count;
    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
    logic [DEPTH_LOG2:0]   r_rx_count;

    logic                  r_ack;
    logic [15:0]           r_cpu_data_read;
    logic                  r_irq;
    logic                  r_rx_overrun;
    logic                  r_rx_taken;

    logic                  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                  w_req, w_rd, w_wr;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic                  w_rx_uart_push;
    logic                  w_set_taken, w_clr_taken;
    logic                  w_ack_next;
    logic                  w_ovr_set, w_ovr_clear;
    logic                  w_tx_busy;
    logic [7:0]            w_status;
    logic [15:0]           w_rd_data;
    logic [DEPTH_LOG2:0]   w_rx_count_next;

    assign w_tx_full  = (r_tx_count == FULL_CNT);
    assign w_tx_empty = (r_tx_count == '0);
    assign w_rx_full  = (r_rx_count == FULL_CNT);
    assign w_rx_empty = (r_rx_count == '0);

    // CPU request decode; a request is only taken while no ack is outstanding
    assign w_req = cpu.cpu_cs && (cpu.cpu_addr == BASE_ADDR) && !r_ack;
    assign w_rd  = w_req && cpu.cpu_rw;
    assign w_wr  = w_req && !cpu.cpu_rw;

    assign w_rx_pop  = w_rd && cpu.cpu_ds[0] && !cpu.cpu_ds[1] && !w_rx_empty;
    assign w_tx_push = w_wr && cpu.cpu_ds[0] && (!w_tx_full || w_tx_pop);
    // A data write into a full TX FIFO stalls (no ack) until the uart side frees a slot
    assign w_ack_next = w_rd || (w_wr && (!cpu.cpu_ds[0] || w_tx_push));

    assign w_rx_push   = w_rx_uart_push && (!w_rx_full || w_rx_pop);
    assign w_ovr_set   = w_rx_uart_push && w_rx_full && !w_rx_pop;
    assign w_ovr_clear = w_ack_next && w_wr && cpu.cpu_ds[1] && cpu.cpu_data_write[4];

    assign w_tx_busy = !w_tx_empty || u_tx_active;
    assign w_status  = {3'b000, r_rx_overrun, w_rx_full, w_tx_full, w_tx_busy, !w_rx_empty};

    always_comb begin
        w_rd_data = 16'h0000;
        if (cpu.cpu_ds[1]) begin
            w_rd_data = {8'h00, w_status};
        end else if (cpu.cpu_ds[0] && !w_rx_empty) begin
            w_rd_data = {8'h00, r_rx_mem[r_rx_rptr]};
        end
    end

    always_comb begin
        w_rx_count_next = r_rx_count;
        case ({w_rx_push, w_rx_pop})
            2'b10:   w_rx_count_next = r_rx_count + 1'b1;
            2'b01:   w_rx_count_next = r_rx_count - 1'b1;
            default: w_rx_count_next = r_rx_count;
        endcase
    end

    // uart transaction FSM; a pending received byte is served before TX
    always_comb begin
        w_state_next     = r_state;
        u_ds             = 2'b00;
        u_rw             = 1'b1;
        u_data_write     = 16'h0000;
        u_rx_avail_clear = 1'b0;
        w_tx_pop         = 1'b0;
        w_rx_uart_push   = 1'b0;
        w_set_taken      = 1'b0;
        w_clr_taken      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (u_rx_avail && !r_rx_taken) begin
                    w_state_next = ST_RD;
                end else if (!w_tx_empty && !u_tx_active) begin
                    w_state_next = ST_WR;
                end
            end
            ST_RD: begin
                u_ds = 2'b01;
                if (u_ack) begin
                    w_rx_uart_push = 1'b1;
                    w_set_taken    = 1'b1;
                    w_state_next   = ST_CLR;
                end
            end
            ST_CLR: begin
                u_rx_avail_clear = 1'b1;
                if (!u_rx_avail) begin
                    w_clr_taken  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_WR: begin
                u_ds         = 2'b01;
                u_rw         = 1'b0;
                u_data_write = {8'h00, r_tx_mem[r_tx_rptr]};
                if (u_ack) begin
                    w_tx_pop     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_ack           <= 1'b0;
            r_cpu_data_read <= 16'h0000;
            r_irq           <= 1'b0;
            r_rx_overrun    <= 1'b0;
            r_rx_taken      <= 1'b0;
            r_tx_wptr       <= '0;
            r_tx_rptr       <= '0;
            r_tx_count      <= '0;
            r_rx_wptr       <= '0;
            r_rx_rptr       <= '0;
            r_rx_count      <= '0;
        end else begin
            r_state         <= w_state_next;
            r_ack           <= w_ack_next;
            r_cpu_data_read <= w_rd ? w_rd_data : 16'h0000;
            r_irq           <= (w_rx_count_next != '0);

            if (w_ovr_set) begin
                r_rx_overrun <= 1'b1;
            end else if (w_ovr_clear) begin
                r_rx_overrun <= 1'b0;
            end

            if (w_set_taken) begin
                r_rx_taken <= 1'b1;
            end else if (w_clr_taken) begin
                r_rx_taken <= 1'b0;
            end

            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            r_rx_count <= w_rx_count_next;
        end
    end

    // FIFO storage carries no reset; the pointers alone define validity
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= cpu.cpu_data_write[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= u_data_read[7:0];
    end

    assign cpu.cpu_ack       = r_ack;
    assign cpu.cpu_data_read = r_cpu_data_read;
    assign irq               = r_irq;
    assign u_addr            = 8'd0;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: a behavioural uart register-port model plus a
// byte scoreboard for the TX and RX paths.
module tb_uart_fifo_bridge;

    localparam int TX_CYCLES = 12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq;
    logic [7:0]  u_addr;
    logic [1:0]  u_ds;
    logic        u_rw;
    logic [15:0] u_data_write;
    logic [15:0] u_data_read;
    logic        u_ack;
    logic        u_tx_active;
    logic        u_rx_avail;
    logic        u_rx_avail_clear;

    always #5 clk = ~clk;

    uart_fifo_bridge_if bus ();

    uart_fifo_bridge dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu              (bus),
        .irq              (irq),
        .u_addr           (u_addr),
        .u_ds             (u_ds),
        .u_rw             (u_rw),
        .u_data_write     (u_data_write),
        .u_data_read      (u_data_read),
        .u_ack            (u_ack),
        .u_tx_active      (u_tx_active),
        .u_rx_avail       (u_rx_avail),
        .u_rx_avail_clear (u_rx_avail_clear)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    int         m_tx_timer = 0;
    logic [7:0] m_tx_log [256];
    int         m_tx_n = 0;
    int         tx_rd = 0;
    int         m_rx_req = 0;
    int         m_rx_done = 0;
    logic [7:0] m_rx_byte = 8'h00;
    logic       m_force_busy = 1'b0;
    int         m_clr_cycles = 0;

    assign u_tx_active = (m_tx_timer != 0) || m_force_busy;

    // uart register-port model: acks one cycle after a request, serialises TX
    // for TX_CYCLES, raises rx_avail per injected byte and drops it on clear
    always @(posedge clk) begin
        if (u_rx_avail_clear) m_clr_cycles <= m_clr_cycles + 1;
        if (!reset_n) begin
            u_ack       <= 1'b0;
            u_data_read <= 16'h0000;
            m_tx_timer  <= 0;
            u_rx_avail  <= 1'b0;
            m_rx_done   <= m_rx_req;
        end else begin
            u_ack <= 1'b0;
            if (m_tx_timer != 0) m_tx_timer <= m_tx_timer - 1;
            if (u_ds[0] && !u_ack) begin
                u_ack <= 1'b1;
                if (u_rw) begin
                    u_data_read <= {8'h00, m_rx_byte};
                end else begin
                    m_tx_log[m_tx_n[7:0]] <= u_data_write[7:0];
                    m_tx_n <= m_tx_n + 1;
                    m_tx_timer <= TX_CYCLES;
                end
            end
            if (!u_rx_avail && (m_rx_done != m_rx_req)) begin
                u_rx_avail <= 1'b1;
                m_rx_done  <= m_rx_done + 1;
            end else if (u_rx_avail && u_rx_avail_clear) begin
                u_rx_avail <= 1'b0;
            end
        end
    end

    task automatic cpu_xfer(input logic rw, input logic [1:0] ds, input logic [15:0] wd,
                            output logic [15:0] rd, output logic ok);
        ok = 1'b0;
        rd = 16'h0000;
        @(negedge clk);
        bus.cpu_cs = 1'b1;
        bus.cpu_addr = 8'h00;
        bus.cpu_rw = rw;
        bus.cpu_ds = ds;
        bus.cpu_data_write = wd;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                ok = 1'b1;
                rd = bus.cpu_data_read;
                break;
            end
        end
        bus.cpu_cs = 1'b0;
        bus.cpu_ds = 2'b00;
    endtask

    task automatic rd_status(output logic [7:0] s, output logic ok);
        logic [15:0] rd;
        cpu_xfer(1'b1, 2'b10, 16'h0000, rd, ok);
        s = rd[7:0];
    endtask

    task automatic wait_rx_settle(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (m_rx_done == m_rx_req && !u_rx_avail && !u_rx_avail_clear) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic inject(input logic [7:0] b, output logic ok);
        m_rx_byte = b;
        m_rx_req = m_rx_req + 1;
        wait_rx_settle(ok);
    endtask

    task automatic test_reset();
        logic [7:0] s;
        logic ok;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.cpu_ack !== 1'b0 || bus.cpu_data_read !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_cpu: ack=%b data=%h required ack=0 data=0000", bus.cpu_ack, bus.cpu_data_read);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b required 0", irq);
        end
        n_cmp++;
        if (u_ds !== 2'b00 || u_rw !== 1'b1) begin
            n_err++;
            $display("FAIL reset_uart_ctl: ds=%b rw=%b required ds=00 rw=1", u_ds, u_rw);
        end
        n_cmp++;
        if (u_addr !== 8'h00 || u_data_write !== 16'h0000 || u_rx_avail_clear !== 1'b0) begin
            n_err++;
            $display("FAIL reset_uart_data: addr=%h wd=%h clr=%b required 00/0000/0", u_addr, u_data_write, u_rx_avail_clear);
        end
        reset_n = 1'b1;
        rd_status(s, ok);
        n_cmp++;
        if (!ok || s !== 8'h00) begin
            n_err++;
            $display("FAIL reset_status: ok=%b got %h required 00", ok, s);
        end
    endtask

    task automatic test_tx_order();
        logic [7:0]  bytes [3];
        logic [15:0] rd;
        logic [7:0]  s, e, g;
        logic        ok;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(bytes[i]);
            cpu_xfer(1'b0, 2'b01, {8'h00, bytes[i]}, rd, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL tx_write_ack: byte %h not acknowledged", bytes[i]);
            end
            if (i == 0) begin
                @(negedge clk);
                n_cmp++;
                if (u_ds !== 2'b01 || u_rw !== 1'b0 || u_data_write !== 16'h0041) begin
                    n_err++;
                    $display("FAIL tx_latency: ds=%b rw=%b wd=%h required 01/0/0041", u_ds, u_rw, u_data_write);
                end
            end
        end
        rd_status(s, ok);
        n_cmp++;
        if (!ok || s[1] !== 1'b1) begin
            n_err++;
            $display("FAIL tx_busy_set: status %h required bit1=1", s);
        end
        for (int t = 0; t < 200 && (m_tx_n - tx_rd) < 3; t++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            g = (tx_rd < m_tx_n) ? m_tx_log[tx_rd[7:0]] : 8'hZZ;
            tx_rd++;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL tx_order[%0d]: got %h required %h", i, g, e);
            end
        end
        s = 8'hFF;
        for (int t = 0; t < 20 && s[1] !== 1'b0; t++) rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h00) begin
            n_err++;
            $display("FAIL tx_busy_clear: status %h required 00", s);
        end
    endtask

    task automatic test_tx_full();
        logic [15:0] rd;
        logic [7:0]  s, e, g;
        logic        ok;
        int          acks, early, n_exp;
        acks = 0;
        m_force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            cpu_xfer(1'b0, 2'b01, {8'h00, 8'h10 + 8'(i)}, rd, ok);
            if (ok) acks++;
        end
        n_cmp++;
        if (acks != 16) begin
            n_err++;
            $display("FAIL tx_fill_acks: got %0d required 16", acks);
        end
        rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h06) begin
            n_err++;
            $display("FAIL tx_full_status: got %h required 06", s);
        end
        exp_q.push_back(8'hEE);
        @(negedge clk);
        bus.cpu_cs = 1'b1; bus.cpu_addr = 8'h00; bus.cpu_rw = 1'b0;
        bus.cpu_ds = 2'b01; bus.cpu_data_write = 16'h00EE;
        early = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cpu_ack) early = 1;
        end
        n_cmp++;
        if (early != 0) begin
            n_err++;
            $display("FAIL tx_full_waitstate: ack seen while full, required none");
        end
        m_force_busy = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cpu_cs = 1'b0; bus.cpu_ds = 2'b00;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL tx_17th_ack: no ack after slot freed, required ack");
        end
        for (int t = 0; t < 600 && (m_tx_n - tx_rd) < 17; t++) @(negedge clk);
        n_exp = exp_q.size();
        for (int i = 0; i < n_exp; i++) begin
            e = exp_q.pop_front();
            g = (tx_rd < m_tx_n) ? m_tx_log[tx_rd[7:0]] : 8'hZZ;
            tx_rd++;
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL tx_drain[%0d]: got %h required %h", i, g, e);
            end
        end
        repeat (TX_CYCLES + 4) @(negedge clk);
    endtask

    task automatic test_rx_single();
        logic [15:0] rd;
        logic [7:0]  s;
        logic        ok;
        int          clr0;
        clr0 = m_clr_cycles;
        inject(8'h55, ok);
        n_cmp++;
        if (!ok || m_clr_cycles <= clr0 || u_rx_avail_clear !== 1'b0) begin
            n_err++;
            $display("FAIL rx_clear_handshake: settled=%b clr_cycles=%0d clr=%b required settled, >0 cycles, clr=0",
                     ok, m_clr_cycles - clr0, u_rx_avail_clear);
        end
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL rx_irq_set: got %b required 1", irq);
        end
        cpu_xfer(1'b1, 2'b11, 16'h0000, rd, ok);
        n_cmp++;
        if (!ok || rd !== 16'h0001) begin
            n_err++;
            $display("FAIL rx_status_wins: got %h required 0001", rd);
        end
        cpu_xfer(1'b1, 2'b01, 16'h0000, rd, ok);
        n_cmp++;
        if (!ok || rd !== 16'h0055) begin
            n_err++;
            $display("FAIL rx_data: got %h required 0055", rd);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL rx_irq_clear: got %b required 0", irq);
        end
        cpu_xfer(1'b1, 2'b01, 16'h0000, rd, ok);
        n_cmp++;
        if (!ok || rd !== 16'h0000) begin
            n_err++;
            $display("FAIL rx_empty_read: got %h required 0000", rd);
        end
    endtask

    task automatic test_rx_overrun();
        logic [15:0] rd;
        logic [7:0]  s, e;
        logic        ok;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'h60 + 8'(i));
            inject(8'h60 + 8'(i), ok);
        end
        rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h19) begin
            n_err++;
            $display("FAIL rx_overrun_status: got %h required 19", s);
        end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            cpu_xfer(1'b1, 2'b01, 16'h0000, rd, ok);
            n_cmp++;
            if (!ok || rd !== {8'h00, e}) begin
                n_err++;
                $display("FAIL rx_overrun_data[%0d]: got %h required %h", i, rd, {8'h00, e});
            end
        end
        rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h10) begin
            n_err++;
            $display("FAIL rx_overrun_sticky: got %h required 10", s);
        end
        cpu_xfer(1'b0, 2'b10, 16'h0010, rd, ok);
        rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h00) begin
            n_err++;
            $display("FAIL rx_overrun_clear: got %h required 00", s);
        end
    endtask

    task automatic test_rx_simul();
        logic [15:0] rd;
        logic [7:0]  s, e;
        logic        ok;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h80 + 8'(i));
            inject(8'h80 + 8'(i), ok);
        end
        rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h09) begin
            n_err++;
            $display("FAIL rx_full_status: got %h required 09", s);
        end
        m_rx_byte = 8'hA5;
        m_rx_req = m_rx_req + 1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (u_ack && u_rw && u_ds == 2'b01) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cpu_cs = 1'b1; bus.cpu_addr = 8'h00; bus.cpu_rw = 1'b1;
        bus.cpu_ds = 2'b01; bus.cpu_data_write = 16'h0000;
        rd = 16'hFFFF;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                rd = bus.cpu_data_read;
                break;
            end
        end
        bus.cpu_cs = 1'b0; bus.cpu_ds = 2'b00;
        e = exp_q.pop_front();
        exp_q.push_back(8'hA5);
        n_cmp++;
        if (!ok || rd !== {8'h00, e}) begin
            n_err++;
            $display("FAIL rx_simul_pop: aligned=%b got %h required %h", ok, rd, {8'h00, e});
        end
        wait_rx_settle(ok);
        rd_status(s, ok);
        n_cmp++;
        if (s !== 8'h09) begin
            n_err++;
            $display("FAIL rx_simul_status: got %h required 09", s);
        end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            cpu_xfer(1'b1, 2'b01, 16'h0000, rd, ok);
            n_cmp++;
            if (!ok || rd !== {8'h00, e}) begin
                n_err++;
                $display("FAIL rx_simul_data[%0d]: got %h required %h", i, rd, {8'h00, e});
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] rd;
        logic [7:0]  s;
        logic        ok;
        cpu_xfer(1'b0, 2'b01, 16'h0031, rd, ok);
        cpu_xfer(1'b0, 2'b01, 16'h0032, rd, ok);
        cpu_xfer(1'b0, 2'b01, 16'h0033, rd, ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (u_ds == 2'b01 && u_rw == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL mid_tx_reach: no uart write seen, required one");
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (u_ds !== 2'b00 || u_rw !== 1'b1 || u_data_write !== 16'h0000 || u_rx_avail_clear !== 1'b0) begin
            n_err++;
            $display("FAIL mid_tx_uart_reset: ds=%b rw=%b wd=%h clr=%b required 00/1/0000/0",
                     u_ds, u_rw, u_data_write, u_rx_avail_clear);
        end
        n_cmp++;
        if (bus.cpu_ack !== 1'b0 || bus.cpu_data_read !== 16'h0000 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL mid_tx_cpu_reset: ack=%b data=%h irq=%b required 0/0000/0",
                     bus.cpu_ack, bus.cpu_data_read, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tx_rd = m_tx_n;
        rd_status(s, ok);
        n_cmp++;
        if (!ok || s !== 8'h00) begin
            n_err++;
            $display("FAIL mid_tx_status: got %h required 00", s);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (m_tx_n != tx_rd) begin
            n_err++;
            $display("FAIL mid_tx_fifo_lost: %0d bytes sent after reset, required 0", m_tx_n - tx_rd);
        end
    endtask

    initial begin
        bus.cpu_cs = 1'b0;
        bus.cpu_addr = 8'h00;
        bus.cpu_ds = 2'b00;
        bus.cpu_rw = 1'b1;
        bus.cpu_data_write = 16'h0000;
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_single();
        test_rx_overrun();
        test_rx_simul();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
